// File: rtl/bpred_btb_if.sv
// Fetch-side lookup and ID-side update bundle for the branch target buffer.
interface bpred_btb_if #(
  parameter int LENGTH = 32
) ();
  logic [LENGTH-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [LENGTH-1:0] pred_target;
  logic              upd_valid;
  logic [LENGTH-1:0] upd_pc;
  logic              upd_taken;
  logic [LENGTH-1:0] upd_target;
  logic              upd_mispredict;
  logic              flush_all;
  logic [31:0]       stat_lookups;
  logic [31:0]       stat_mispredicts;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
    input  pred_hit, pred_taken, pred_target, stat_lookups, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
    output pred_hit, pred_taken, pred_target, stat_lookups, stat_mispredicts
  );
endinterface

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Define BPRED_STATS_EN to build the lookup / mispredict statistics counters.
module bpred_btb #(
  parameter int LENGTH  = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic       clk,
  input  logic       rst,
  bpred_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_up_tag;
  logic [ENTRIES-1:0] w_valid;
  logic [TAG_W-1:0]  w_tag    [ENTRIES];
  logic [LENGTH-1:0] w_target [ENTRIES];
  logic [CNT_W-1:0]  w_cnt    [ENTRIES];
  logic              w_lk_hit;
  logic              w_lk_taken;
  logic [LENGTH-1:0] w_seq_pc;
  logic              w_unused;

  assign w_lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign w_lk_tag = bus.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_up_idx = bus.upd_pc[IDX_W+1:2];
  assign w_up_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [LENGTH-1:0] r_target;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_sel;
    logic              w_hit;
    logic [CNT_W-1:0]  w_cnt_next;

    // flush_all wins over a same-cycle update, so it masks the select
    assign w_sel = bus.upd_valid && !bus.flush_all && (w_up_idx == IDX_W'(gi));
    assign w_hit = r_valid && (r_tag == w_up_tag);

    always_comb begin
      w_cnt_next = r_cnt;
      if (bus.upd_taken) begin
        if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + CNT_W'(1);
      end else begin
        if (r_cnt != '0) w_cnt_next = r_cnt - CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_valid  <= 1'b0;
        r_tag    <= '0;
        r_target <= '0;
        r_cnt    <= CNT_WNT;
      end else if (bus.flush_all) begin
        r_valid <= 1'b0;
      end else if (w_sel) begin
        if (w_hit) begin
          r_cnt <= w_cnt_next;
          if (bus.upd_taken) r_target <= bus.upd_target;
        end else if (bus.upd_taken) begin
          r_valid  <= 1'b1;
          r_tag    <= w_up_tag;
          r_target <= bus.upd_target;
          r_cnt    <= CNT_WT;
        end
      end
    end

    assign w_valid[gi]  = r_valid;
    assign w_tag[gi]    = r_tag;
    assign w_target[gi] = r_target;
    assign w_cnt[gi]    = r_cnt;
  end

  // Lookup reads the registered table, so a same-cycle update is seen next cycle
  assign w_lk_hit   = w_valid[w_lk_idx] && (w_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && w_cnt[w_lk_idx][CNT_W-1];
  assign w_seq_pc   = bus.lookup_pc + LENGTH'(4);

  assign bus.pred_hit    = w_lk_hit;
  assign bus.pred_taken  = w_lk_taken;
  assign bus.pred_target = w_lk_taken ? w_target[w_lk_idx] : w_seq_pc;

`ifdef BPRED_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_lookups     <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (r_stat_lookups != 32'hFFFF_FFFF) r_stat_lookups <= r_stat_lookups + 32'd1;
      if (bus.upd_valid && bus.upd_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF))
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign bus.stat_lookups     = r_stat_lookups;
  assign bus.stat_mispredicts = r_stat_mispredicts;
  assign w_unused = ^{bus.lookup_pc, bus.upd_pc};
`else
  assign bus.stat_lookups     = 32'd0;
  assign bus.stat_mispredicts = 32'd0;
  assign w_unused = ^{bus.lookup_pc, bus.upd_pc, bus.upd_mispredict};
`endif

endmodule

// File: tb/tb_bpred_btb.sv
// Randomized self-checking bench for bpred_btb against a table-level reference model.
module tb_bpred_btb;
  localparam int LENGTH  = 32;
  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int CNT_WT  = 1 << (CNT_W - 1);
  localparam int CNT_WNT = CNT_WT - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bpred_btb_if #(.LENGTH(LENGTH)) bus ();

  bpred_btb #(
    .LENGTH(LENGTH), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one record per direct-mapped slot
  bit          m_valid  [ENTRIES];
  int          m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  longint      m_lookups;
  longint      m_misp;

  logic        obs_hit, obs_taken;
  logic [31:0] obs_tgt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (2 + $clog2(ENTRIES))) % (1 << TAG_W));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = '0; m_cnt[i] = CNT_WNT;
    end
    m_lookups = 0;
    m_misp    = 0;
  endtask

  task automatic model_pred(input logic [31:0] pc, output bit hit, output bit tk,
                            output logic [31:0] tgt);
    int i;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    tk  = hit && (m_cnt[i] >= CNT_WT);
    tgt = tk ? m_target[i] : pc + 32'd4;
  endtask

  task automatic model_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    int i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      if (tk) begin
        m_cnt[i]    = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
        m_target[i] = tgt;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1; m_tag[i] = tag_of(pc); m_target[i] = tgt; m_cnt[i] = CNT_WT;
    end
  endtask

  task automatic chk_stats();
`ifdef BPRED_STATS_EN
    chk("stat_lookups", bus.stat_lookups, m_lookups);
    chk("stat_mispredicts", bus.stat_mispredicts, m_misp);
`else
    chk("stat_lookups_off", bus.stat_lookups, 0);
    chk("stat_mispredicts_off", bus.stat_mispredicts, 0);
`endif
  endtask

  // One cycle: drive at negedge, check lookup mid-cycle, apply model at posedge
  task automatic do_cycle(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                          input bit ut, input logic [31:0] utgt, input bit um, input bit fl);
    bit e_hit, e_tk;
    logic [31:0] e_tgt;
    bus.lookup_pc = lpc; bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut;
    bus.upd_target = utgt; bus.upd_mispredict = um; bus.flush_all = fl;
    #1;
    model_pred(lpc, e_hit, e_tk, e_tgt);
    obs_hit = bus.pred_hit; obs_taken = bus.pred_taken; obs_tgt = bus.pred_target;
    chk("pred_hit", obs_hit, e_hit);
    chk("pred_taken", obs_taken, e_tk);
    chk("pred_target", obs_tgt, e_tgt);
    $display("cyc lpc=%08h hit=%0b tk=%0b tgt=%08h | uv=%0b upc=%08h ut=%0b utgt=%08h fl=%0b",
             lpc, obs_hit, obs_taken, obs_tgt, uv, upc, ut, utgt, fl);
    @(posedge clk);
    if (rst) m_lookups = (m_lookups < 64'hFFFF_FFFF) ? m_lookups + 1 : m_lookups;
    if (uv && um) m_misp++;
    if (fl) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      model_update(upc, ut, utgt);
    end
    @(negedge clk);
    chk_stats();
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    pc = ($urandom << 14) | (32'($urandom_range(0, 3)) << 6)
       | (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
    return pc;
  endfunction

  initial begin
    bus.lookup_pc = 32'h40; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0;
    bus.upd_target = 0; bus.upd_mispredict = 0; bus.flush_all = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hit", bus.pred_hit, 0);
    chk("reset_target", bus.pred_target, 32'h44);
    chk_stats();
    @(negedge clk);
    rst = 1'b1;

    // 10 cycles out of reset, 3 mispredict reports that allocate nothing
    for (int c = 0; c < 10; c++)
      do_cycle(32'h40, (c % 3 == 0) && c < 9, 32'h44, 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef BPRED_STATS_EN
    chk("stat_lookups_10", bus.stat_lookups, 10);
    chk("stat_misp_3", bus.stat_mispredicts, 3);
`endif
    chk("cold_hit", obs_hit, 0);
    chk("cold_target", obs_tgt, 32'h44);

    do_cycle(32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
    do_cycle(32'h40, 0, 0, 0, 0, 0, 0);
    chk("alloc_hit", obs_hit, 1);
    chk("alloc_target", obs_tgt, 32'h100);

    for (int k = 0; k < 3; k++) do_cycle(32'h40, 1, 32'h40, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) do_cycle(32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
    do_cycle(32'h40, 1, 32'h40, 0, 0, 0, 0);
    chk("sat_taken_at_3", obs_taken, 1);
    do_cycle(32'h40, 0, 0, 0, 0, 0, 0);
    chk("taken_at_2", obs_taken, 1);

    do_cycle(32'h3040, 0, 0, 0, 0, 0, 0);
    chk("alias_miss", obs_hit, 0);
    chk("alias_target", obs_tgt, 32'h3044);
    do_cycle(32'h3040, 1, 32'h3040, 1, 32'h200, 0, 0);
    do_cycle(32'h3040, 0, 0, 0, 0, 0, 0);
    chk("alias_evict_tgt", obs_tgt, 32'h200);
    do_cycle(32'h40, 0, 0, 0, 0, 0, 0);
    chk("alias_old_miss", obs_hit, 0);

    do_cycle(32'h3040, 1, 32'h3040, 1, 32'h500, 0, 1);
    do_cycle(32'h80, 1, 32'h80, 1, 32'h400, 0, 0);
    chk("same_cycle_miss", obs_hit, 0);
    do_cycle(32'h80, 0, 0, 0, 0, 0, 0);
    chk("same_cycle_next", obs_tgt, 32'h400);

    do_cycle(32'hFFFF_FFFC, 1, 32'h1C0, 1, 32'h600, 1, 1);
    do_cycle(32'h1C0, 0, 0, 0, 0, 0, 0);
    chk("flush_drop", obs_hit, 0);
    do_cycle(32'h80, 0, 0, 0, 0, 0, 0);
    chk("flush_miss", obs_hit, 0);
    do_cycle(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    chk("wrap_target", obs_tgt, 32'h0);

    for (int c = 0; c < 400; c++) begin
      logic [31:0] upc;
      upc = rnd_pc();
      do_cycle(($urandom_range(0, 1) == 1) ? upc : rnd_pc(), $urandom_range(0, 3) != 0, upc,
               $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1),
               $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset asserted mid-cycle
    bus.lookup_pc = 32'h80; bus.upd_valid = 0; bus.flush_all = 0;
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_hit", bus.pred_hit, 0);
    chk("async_rst_target", bus.pred_target, 32'h84);
    chk_stats();
    @(negedge clk);
    rst = 1'b1;
    do_cycle(32'h80, 1, 32'h80, 1, 32'h700, 1, 0);
    do_cycle(32'h80, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
